// File: rtl/csa_result_buffer_pkg.sv
// Shared adder types: result word layout and status-flag computation.
package csa_result_buffer_pkg;

   localparam int ADD_WIDTH = 64;

   typedef struct packed {
      logic [ADD_WIDTH-1:0] sum;
      logic                 carry;
      logic                 zero;
      logic                 neg;
      logic                 ovf;
   } add_result_t;

   // Build a result word with its flags. Signed overflow occurs when both
   // operands share a sign and the sum's sign differs from it.
   function automatic add_result_t make_result(input logic [ADD_WIDTH-1:0] sum,
                                               input logic                 carry,
                                               input logic                 a_msb,
                                               input logic                 b_msb);
      add_result_t r;
      r.sum   = sum;
      r.carry = carry;
      r.zero  = (sum == '0);
      r.neg   = sum[ADD_WIDTH-1];
      r.ovf   = (a_msb == b_msb) && (sum[ADD_WIDTH-1] != a_msb);
      return r;
   endfunction

endpackage

// File: rtl/csa_result_buffer_result_fifo_mem.sv
// DEPTH-entry storage array for adder results; one write port, one async read.
module result_fifo_mem
   import csa_result_buffer_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic        clk,
   input  logic        we,
   input  logic [AW-1:0] waddr,
   input  add_result_t wdata,
   input  logic [AW-1:0] raddr,
   output add_result_t rdata
);

   add_result_t mem [DEPTH];

   // Storage is not reset; validity is tracked by the parent's occupancy.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/csa_result_buffer.sv
// Registers carry-select adder results with status flags in a small FIFO,
// exposes them via valid/ready, and counts carry-producing results.
module csa_result_buffer
   import csa_result_buffer_pkg::*;
#(
   parameter int WIDTH = ADD_WIDTH,
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         S,
   input  logic                     C_Out,
   input  logic                     A_msb,
   input  logic                     B_msb,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_sum,
   output logic                     out_carry,
   output logic                     out_zero,
   output logic                     out_neg,
   output logic                     out_ovf,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic [CNT_W-1:0]         carry_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;
   localparam logic [OW-1:0] FULL_OCC = OW'(DEPTH);

   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          push, pop;
   add_result_t   wdata, rdata;

   // Ready and valid come from registered state only, so out_ready never
   // reaches in_ready combinationally and a full buffer refuses a push
   // even when a pop happens in the same cycle.
   assign in_ready  = rst_n & (occupancy < FULL_OCC);
   assign out_valid = (occupancy != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   assign wdata = make_result(S, C_Out, A_msb, B_msb);

   result_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (wdata),
      .raddr (rd_ptr),
      .rdata (rdata)
   );

   assign out_sum   = rdata.sum;
   assign out_carry = rdata.carry;
   assign out_zero  = rdata.zero;
   assign out_neg   = rdata.neg;
   assign out_ovf   = rdata.ovf;

   // Pointers wrap naturally since DEPTH is a power of two; full/empty
   // is judged from occupancy, never from pointer equality.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
   end

   // Occupancy: push and pop together leave it unchanged.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         occupancy <= '0;
      end else begin
         case ({push, pop})
            2'b10:   occupancy <= occupancy + OW'(1);
            2'b01:   occupancy <= occupancy - OW'(1);
            default: occupancy <= occupancy;
         endcase
      end
   end

   // Saturating count of accepted results that produced a carry-out.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         carry_count <= '0;
      end else if (push && C_Out && (carry_count != '1)) begin
         carry_count <= carry_count + CNT_W'(1);
      end
   end

endmodule
